// File: rtl/stream_to_ram_writer.sv
// Stream-to-RAM writer: valid/ready beats go to consecutive RAM addresses from a base, with frame-length checking.
// Optional macro STREAM_TO_RAM_WRITER_OUT_REG_EN registers the write port and delays done_o/words_o by one cycle.
module stream_to_ram_writer #(
  parameter  int DATA_WIDTH       = 8,
  parameter  int ADDR_WIDTH       = 8,
  localparam int BYTE_VALID_WIDTH = DATA_WIDTH / 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [ADDR_WIDTH-1:0]       base_addr_i,
  input  logic [ADDR_WIDTH:0]         len_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [DATA_WIDTH-1:0]       s_data_i,
  input  logic [BYTE_VALID_WIDTH-1:0] s_keep_i,
  input  logic                        s_last_i,
  output logic                        wr_en_o,
  output logic [DATA_WIDTH-1:0]       wr_data_o,
  output logic [BYTE_VALID_WIDTH-1:0] wr_byte_valid_o,
  output logic [ADDR_WIDTH-1:0]       wr_addr_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [ADDR_WIDTH:0]         words_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                      r_state;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic [ADDR_WIDTH:0]         r_len;
  logic [ADDR_WIDTH:0]         r_words;
  logic                        r_err;
  logic                        r_done;

  logic                        w_busy;
  logic                        w_hs;
  logic                        w_wr_en;
  logic                        w_start_ok;
  logic [ADDR_WIDTH:0]         w_words_next;
  logic [ADDR_WIDTH-1:0]       w_wr_addr;
  logic [DATA_WIDTH-1:0]       w_wr_data;
  logic [BYTE_VALID_WIDTH-1:0] w_wr_bv;

  assign w_busy       = (r_state != S_IDLE);
  assign w_hs         = s_valid_i & w_busy;
  assign w_wr_en      = w_hs & (r_state == S_RUN);
  assign w_words_next = r_words + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Write fields are forced to zero outside a write so the port idles at its reset values.
  assign w_wr_addr = w_wr_en ? (r_base + r_words[ADDR_WIDTH-1:0]) : '0;
  assign w_wr_data = w_wr_en ? s_data_i : '0;
  assign w_wr_bv   = w_wr_en ? s_keep_i : '0;

  assign s_ready_o = w_busy;
  assign busy_o    = w_busy;
  assign err_o     = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i && (len_i != '0) && w_start_ok) begin
            r_base  <= base_addr_i;
            r_len   <= len_i;
            r_words <= '0;
            r_err   <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_words <= w_words_next;
            if (s_last_i) begin
              // A last beat before the programmed count is a short frame.
              r_err   <= (w_words_next != r_len);
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_words_next == r_len) begin
              r_err   <= 1'b1;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_hs && s_last_i) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STREAM_TO_RAM_WRITER_OUT_REG_EN
  logic                        r_wr_en;
  logic [DATA_WIDTH-1:0]       r_wr_data;
  logic [BYTE_VALID_WIDTH-1:0] r_wr_bv;
  logic [ADDR_WIDTH-1:0]       r_wr_addr;
  logic                        r_done_d;
  logic [ADDR_WIDTH:0]         r_words_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_wr_bv   <= '0;
      r_wr_addr <= '0;
      r_done_d  <= 1'b0;
      r_words_d <= '0;
    end else begin
      r_wr_en   <= w_wr_en;
      r_wr_data <= w_wr_data;
      r_wr_bv   <= w_wr_bv;
      r_wr_addr <= w_wr_addr;
      r_done_d  <= r_done;
      r_words_d <= r_words;
    end
  end

  assign wr_en_o         = r_wr_en;
  assign wr_data_o       = r_wr_data;
  assign wr_byte_valid_o = r_wr_bv;
  assign wr_addr_o       = r_wr_addr;
  assign done_o          = r_done_d;
  assign words_o         = r_words_d;
  // Hold off a new start until the delayed done pulse is visible.
  assign w_start_ok      = ~r_done;
`else
  assign wr_en_o         = w_wr_en;
  assign wr_data_o       = w_wr_data;
  assign wr_byte_valid_o = w_wr_bv;
  assign wr_addr_o       = w_wr_addr;
  assign done_o          = r_done;
  assign words_o         = r_words;
  assign w_start_ok      = 1'b1;
`endif

endmodule

// File: tb/tb_stream_to_ram_writer.sv
// Self-checking bench for stream_to_ram_writer: directed frames with literal expectations, then random
// stimulus compared every cycle against a frame-level behavioural model (handles both build variants).
module tb_stream_to_ram_writer;

  localparam int DW = 8;
  localparam int AW = 8;
`ifdef STREAM_TO_RAM_WRITER_OUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   len_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic [0:0]    s_keep_i;
  logic          s_last_i;
  logic          wr_en_o;
  logic [DW-1:0] wr_data_o;
  logic [0:0]    wr_byte_valid_o;
  logic [AW-1:0] wr_addr_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;
  logic [AW:0]   words_o;

  int nCompared = 0;
  int nMismatch = 0;
  int wrCount   = 0;
  int doneCount = 0;
  logic [DW-1:0] ram [0:255];

  // Frame-level reference state: what the block must be doing after each clock edge.
  logic          mBusy, mDrain, mErr, mDone;
  logic [AW-1:0] mBase;
  int            mLen, mWords;
  logic          pWrEn, pWrKeep, pDone;
  logic [DW-1:0] pWrData;
  logic [AW-1:0] pWrAddr;
  int            pWords;

  stream_to_ram_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_keep_i(s_keep_i),
    .s_last_i(s_last_i), .wr_en_o(wr_en_o), .wr_data_o(wr_data_o),
    .wr_byte_valid_o(wr_byte_valid_o), .wr_addr_o(wr_addr_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .words_o(words_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [AW-1:0] base, input logic [AW:0] len,
                               input logic v, input logic [DW-1:0] d, input logic k, input logic l);
    start_i     = st;
    base_addr_i = base;
    len_i       = len;
    s_valid_i   = v;
    s_data_i    = d;
    s_keep_i    = k;
    s_last_i    = l;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // RAM stand-in: captures what the write port presents at each clock edge.
  always @(posedge clk_i) begin
    if (!rst_i && wr_en_o === 1'b1) begin
      wrCount++;
      if (wr_byte_valid_o[0]) ram[wr_addr_o] = wr_data_o;
    end
  end

  // Per-cycle compare against the model, then advance the model over the coming edge.
  always @(negedge clk_i) begin
    logic hs, cWrEn, cKeep, eWrEn, eKeep, eDone, newDone;
    logic [DW-1:0] cData, eData;
    logic [AW-1:0] cAddr, eAddr;
    int eWords;
    if (rst_i) begin
      checkOutput("rst_ready", 32'(s_ready_o), 32'(0));
      checkOutput("rst_busy", 32'(busy_o), 32'(0));
      checkOutput("rst_wr_en", 32'(wr_en_o), 32'(0));
      checkOutput("rst_wr_data", 32'(wr_data_o), 32'(0));
      checkOutput("rst_wr_bv", 32'(wr_byte_valid_o), 32'(0));
      checkOutput("rst_wr_addr", 32'(wr_addr_o), 32'(0));
      checkOutput("rst_done", 32'(done_o), 32'(0));
      checkOutput("rst_err", 32'(err_o), 32'(0));
      checkOutput("rst_words", 32'(words_o), 32'(0));
      mBusy = 0; mDrain = 0; mErr = 0; mDone = 0; mBase = '0; mLen = 0; mWords = 0;
      pWrEn = 0; pWrKeep = 0; pDone = 0; pWrData = '0; pWrAddr = '0; pWords = 0;
    end else begin
      hs    = s_valid_i & mBusy;
      cWrEn = hs & ~mDrain;
      cAddr = cWrEn ? AW'(int'(mBase) + mWords) : '0;
      cData = cWrEn ? s_data_i : '0;
      cKeep = cWrEn ? s_keep_i[0] : 1'b0;
      eWrEn  = REG_OUT ? pWrEn : cWrEn;
      eAddr  = REG_OUT ? pWrAddr : cAddr;
      eData  = REG_OUT ? pWrData : cData;
      eKeep  = REG_OUT ? pWrKeep : cKeep;
      eDone  = REG_OUT ? pDone : mDone;
      eWords = REG_OUT ? pWords : mWords;
      checkOutput("ready", 32'(s_ready_o), 32'(mBusy));
      checkOutput("busy", 32'(busy_o), 32'(mBusy));
      checkOutput("wr_en", 32'(wr_en_o), 32'(eWrEn));
      checkOutput("done", 32'(done_o), 32'(eDone));
      checkOutput("err", 32'(err_o), 32'(mErr));
      checkOutput("words", 32'(words_o), 32'(eWords));
      if (eWrEn) begin
        checkOutput("wr_addr", 32'(wr_addr_o), 32'(eAddr));
        checkOutput("wr_data", 32'(wr_data_o), 32'(eData));
        checkOutput("wr_bv", 32'(wr_byte_valid_o), 32'(eKeep));
      end
      if (done_o === 1'b1) doneCount++;
      pWrEn = cWrEn; pWrAddr = cAddr; pWrData = cData; pWrKeep = cKeep;
      pDone = mDone; pWords = mWords;
      newDone = 0;
      if (!mBusy) begin
        if (start_i && len_i != 0 && !(REG_OUT && mDone)) begin
          mBusy = 1; mDrain = 0; mBase = base_addr_i; mLen = int'(len_i); mWords = 0; mErr = 0;
        end
      end else if (hs) begin
        if (!mDrain) begin
          mWords = mWords + 1;
          if (s_last_i) begin
            mErr = (mWords != mLen); newDone = 1; mBusy = 0;
          end else if (mWords == mLen) begin
            mErr = 1; mDrain = 1;
          end
        end else if (s_last_i) begin
          newDone = 1; mBusy = 0; mDrain = 0;
        end
      end
      mDone = newDone;
    end
  end

  initial begin
    int w0, d0;
    rst_i = 1'b1;
    start_i = 0; base_addr_i = '0; len_i = '0; s_valid_i = 0; s_data_i = '0; s_keep_i = '0; s_last_i = 0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h5A;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    $display("[TB] normal frame with address wrap");
    w0 = wrCount; d0 = doneCount;
    applyStimulus(1, 8'hFE, 9'd4, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'h11, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'h22, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'h33, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'h44, 1, 1);
    idle(3);
    checkOutput("normal_ram_FE", 32'(ram[8'hFE]), 32'h11);
    checkOutput("normal_ram_FF", 32'(ram[8'hFF]), 32'h22);
    checkOutput("normal_ram_00", 32'(ram[8'h00]), 32'h33);
    checkOutput("normal_ram_01", 32'(ram[8'h01]), 32'h44);
    checkOutput("normal_words", 32'(words_o), 32'd4);
    checkOutput("normal_err", 32'(err_o), 32'd0);
    checkOutput("normal_writes", 32'(wrCount - w0), 32'd4);
    checkOutput("normal_dones", 32'(doneCount - d0), 32'd1);

    $display("[TB] short frame");
    w0 = wrCount; d0 = doneCount;
    applyStimulus(1, 8'h10, 9'd5, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hA1, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hA2, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hA3, 1, 1);
    idle(3);
    checkOutput("short_ram_12", 32'(ram[8'h12]), 32'hA3);
    checkOutput("short_words", 32'(words_o), 32'd3);
    checkOutput("short_err", 32'(err_o), 32'd1);
    checkOutput("short_writes", 32'(wrCount - w0), 32'd3);
    checkOutput("short_dones", 32'(doneCount - d0), 32'd1);

    $display("[TB] long frame");
    w0 = wrCount; d0 = doneCount;
    applyStimulus(1, 8'h20, 9'd2, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hB1, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hB2, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hB3, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hB4, 1, 1);
    idle(3);
    checkOutput("long_ram_21", 32'(ram[8'h21]), 32'hB2);
    checkOutput("long_ram_22", 32'(ram[8'h22]), 32'h5A);
    checkOutput("long_words", 32'(words_o), 32'd2);
    checkOutput("long_err", 32'(err_o), 32'd1);
    checkOutput("long_writes", 32'(wrCount - w0), 32'd2);
    checkOutput("long_dones", 32'(doneCount - d0), 32'd1);

    $display("[TB] keep=0 beat and valid gaps");
    w0 = wrCount; d0 = doneCount;
    applyStimulus(1, 8'h30, 9'd3, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hAA, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 0, 8'hBB, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hCC, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 0, 8'hEE, 1, 1);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hDD, 1, 1);
    idle(3);
    checkOutput("keep_ram_30", 32'(ram[8'h30]), 32'h5A);
    checkOutput("keep_ram_31", 32'(ram[8'h31]), 32'hCC);
    checkOutput("keep_ram_32", 32'(ram[8'h32]), 32'hDD);
    checkOutput("keep_words", 32'(words_o), 32'd3);
    checkOutput("keep_err", 32'(err_o), 32'd0);
    checkOutput("keep_writes", 32'(wrCount - w0), 32'd3);

    $display("[TB] reset during a frame");
    applyStimulus(1, 8'h40, 9'd4, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hC1, 1, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'hC2, 1, 0);
    s_valid_i = 1; s_data_i = 8'hC3; s_keep_i = 1'b1;
    #2 rst_i = 1'b1;
    #1;
    checkOutput("async_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("async_rst_wr_en", 32'(wr_en_o), 32'd0);
    checkOutput("async_rst_words", 32'(words_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    s_valid_i = 0;
    checkOutput("rst_ram_40", 32'(ram[8'h40]), 32'hC1);
    w0 = wrCount; d0 = doneCount;
    applyStimulus(1, 8'h50, 9'd1, 0, 8'h00, 0, 0);
    applyStimulus(0, 8'h00, 9'd0, 1, 8'h77, 1, 1);
    idle(3);
    checkOutput("after_rst_ram_50", 32'(ram[8'h50]), 32'h77);
    checkOutput("after_rst_words", 32'(words_o), 32'd1);
    checkOutput("after_rst_err", 32'(err_o), 32'd0);
    checkOutput("after_rst_dones", 32'(doneCount - d0), 32'd1);
    checkOutput("after_rst_writes", 32'(wrCount - w0), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom % 4) == 0, AW'($urandom), (AW+1)'($urandom_range(0, 7)),
                    ($urandom % 3) != 0, DW'($urandom), 1'($urandom), ($urandom % 4) == 0);
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
